// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory controller.
package spi_mem_pkg;

    // Controller phases, in transaction order.
    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StDone
    } state_e;

    localparam logic [7:0] SPI_OP_READ  = 8'h03;
    localparam logic [7:0] SPI_OP_WRITE = 8'h02;

    // req_size encodings.
    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;
    localparam logic [1:0] SizeRsvd = 2'd3;

    // Number of data bytes moved for a request size; the reserved code acts as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SizeByte: return 3'd1;
            SizeHalf: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    // Reverse byte order so that byte 0 lands in the most significant lane.
    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// Mode-0 SPI bit engine: sclk phase toggle, bit counter, TX and RX shift registers.
// A load starts a field of 1..32 bits taken MSB first from load_data_i; the first
// bit is on mosi in the cycle after the load edge with sclk low.
module spi_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic [5:0]  load_bits_i,
    input  logic        sample_en_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        last_o,
    output logic [31:0] rx_o
);

    logic        active_q;
    logic        sclk_q;
    logic        mosi_q;
    logic [31:0] tx_q;
    logic [31:0] rx_q;
    logic [4:0]  cnt_q;

    // High during the sclk-high half of the final bit: the next edge ends the field.
    assign last_o = active_q & sclk_q & (cnt_q == 5'd0);
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign rx_o   = rx_q;

    // Bit engine: load has priority so a new field can follow the previous one seamlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            active_q <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= load_data_i[31];
            tx_q     <= {load_data_i[30:0], 1'b0};
            rx_q     <= '0;
            cnt_q    <= 5'(load_bits_i - 6'd1);
        end else if (active_q) begin
            if (!sclk_q) begin
                // Rising sclk edge: the device has held miso stable through the low half.
                sclk_q <= 1'b1;
                if (sample_en_i) begin
                    rx_q <= {rx_q[30:0], miso_i};
                end
            end else begin
                sclk_q <= 1'b0;
                if (cnt_q == 5'd0) begin
                    active_q <= 1'b0;
                    mosi_q   <= 1'b0;
                end else begin
                    mosi_q <= tx_q[31];
                    tx_q   <= {tx_q[30:0], 1'b0};
                    cnt_q  <= cnt_q - 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI memory controller: turns single core load/store requests into mode-0 SPI
// read (0x03) / write (0x02) transactions on cs1 (flash) or cs2 (RAM).
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs1,
    output logic              cs2
);

    state_e              state_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          nbytes_q;
    logic [31:0]         wdata_q;
    logic                cs1_q;
    logic                cs2_q;
    logic                resp_valid_q;
    logic [31:0]         resp_rdata_q;

    logic                sh_load;
    logic [31:0]         sh_data;
    logic [5:0]          sh_bits;
    logic                sh_last;
    logic                sh_sample;
    logic [31:0]         sh_rx;
    logic [31:0]         addr_left;
    logic [31:0]         rx_fmt;

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign cs1        = cs1_q;
    assign cs2        = cs2_q;

    // Address left-justified so its MSB is the first bit shifted out.
    assign addr_left = 32'(addr_q) << (32 - ADDR_W);

    // Received bytes arrive byte 0 first, so byte 0 ends up highest in sh_rx.
    assign rx_fmt = bswap32(sh_rx) >> (6'd32 - {nbytes_q, 3'b000});

    assign sh_sample = (state_q == StData) & ~write_q;

    // Shifter field loads: command on acceptance, then address, then data.
    always_comb begin
        sh_load = 1'b0;
        sh_data = '0;
        sh_bits = '0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    sh_load = 1'b1;
                    sh_data = {(req_write ? SPI_OP_WRITE : SPI_OP_READ), 24'h0};
                    sh_bits = 6'd8;
                end
            end
            StCmd: begin
                if (sh_last) begin
                    sh_load = 1'b1;
                    sh_data = addr_left;
                    sh_bits = 6'(ADDR_W);
                end
            end
            StAddr: begin
                if (sh_last) begin
                    sh_load = 1'b1;
                    sh_data = write_q ? bswap32(wdata_q) : 32'h0;
                    sh_bits = {nbytes_q, 3'b000};
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM with request capture, chip-select decode and response formatting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            addr_q       <= '0;
            nbytes_q     <= 3'd1;
            wdata_q      <= '0;
            cs1_q        <= 1'b1;
            cs2_q        <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr[ADDR_W-1:0];
                        nbytes_q <= size_bytes(req_size);
                        wdata_q  <= req_wdata;
                        cs1_q    <= req_addr[ADDR_W];
                        cs2_q    <= ~req_addr[ADDR_W];
                        state_q  <= StCmd;
                    end
                end
                StCmd: begin
                    if (sh_last) begin
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (sh_last) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (sh_last) begin
                        cs1_q        <= 1'b1;
                        cs2_q        <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= write_q ? 32'h0 : rx_fmt;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    spi_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (sh_load),
        .load_data_i (sh_data),
        .load_bits_i (sh_bits),
        .sample_en_i (sh_sample),
        .miso_i      (miso),
        .sclk_o      (sclk),
        .mosi_o      (mosi),
        .last_o      (sh_last),
        .rx_o        (sh_rx)
    );

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: an SPI memory device model answers on miso and records
// mosi; expected results come from a byte-addressed reference memory.
module tb_spi_mem_ctrl;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [24:0] req_addr  = '0;
    logic [1:0]  req_size  = '0;
    logic [31:0] req_wdata = '0;
    logic        miso      = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        cs1;
    logic        cs2;

    always #5 clk = ~clk;

    spi_mem_ctrl #(.ADDR_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .cs1        (cs1),
        .cs2        (cs2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memories ----------------
    logic [7:0] dev_mem [int];
    logic [7:0] ref_mem [int];

    function automatic int mkey(input int dev, input logic [23:0] a);
        return (dev << 24) | int'({8'h00, a});
    endfunction

    function automatic logic [7:0] dflt(input int k);
        logic [31:0] h;
        h = 32'(k) * 32'd2654435761;
        return h[23:16];
    endfunction

    function automatic logic [7:0] dev_get(input int k);
        if (dev_mem.exists(k)) return dev_mem[k];
        return dflt(k);
    endfunction

    function automatic logic [7:0] ref_get(input int k);
        if (ref_mem.exists(k)) return ref_mem[k];
        return dflt(k);
    endfunction

    task automatic preload(input int dev, input logic [23:0] a, input logic [7:0] d);
        dev_mem[mkey(dev, a)] = d;
        ref_mem[mkey(dev, a)] = d;
    endtask

    function automatic int size_nb(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input int dev, input logic [23:0] a, input int nb);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_get(mkey(dev, a + 24'(i)));
        return v;
    endfunction

    task automatic model_write(input int dev, input logic [23:0] a, input int nb,
                               input logic [31:0] wd);
        for (int i = 0; i < nb; i++) ref_mem[mkey(dev, a + 24'(i))] = wd[8*i +: 8];
    endtask

    // ---------------- SPI device model ----------------
    bit   sl_active = 1'b0;
    int   sl_dev    = 0;
    int   sl_low    = 0;
    int   sl_b      = 0;
    int   both_low  = 0;
    logic [23:0] sl_a;
    bit   sl_bits[$];
    bit   last_bits[$];
    int   last_dev  = -1;
    int   last_low  = 0;

    function automatic logic [31:0] sl_field(input int start, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v = {v[30:0], (start + i < sl_bits.size()) ? logic'(sl_bits[start + i]) : 1'b0};
        return v;
    endfunction

    function automatic logic [31:0] last_field(input int start, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v = {v[30:0], (start + i < last_bits.size()) ? logic'(last_bits[start + i]) : 1'b0};
        return v;
    endfunction

    function automatic logic slave_bit(input int b);
        logic [7:0] d;
        int k;
        if (b < 32 || sl_field(0, 8) != 32'h03) return 1'b0;
        k = b - 32;
        d = dev_get(mkey(sl_dev, 24'(sl_field(8, 24) + 32'(k / 8))));
        return d[7 - (k % 8)];
    endfunction

    // Device: one bit per sclk-low cycle while selected; writes commit whole bytes on deselect.
    always @(negedge clk) begin
        if (!cs1 && !cs2) both_low++;
        if (!cs1 || !cs2) begin
            if (!sl_active) begin
                sl_active = 1'b1;
                sl_bits.delete();
                sl_dev = cs1 ? 1 : 0;
                sl_low = 0;
            end
            sl_low++;
            if (!sclk) begin
                sl_b = sl_bits.size();
                sl_bits.push_back(mosi);
                miso = slave_bit(sl_b);
            end
        end else if (sl_active) begin
            sl_active = 1'b0;
            if (sl_bits.size() >= 40 && sl_field(0, 8) == 32'h02) begin
                sl_a = sl_field(8, 24);
                for (int i = 0; i < (sl_bits.size() - 32) / 8; i++)
                    dev_mem[mkey(sl_dev, sl_a + 24'(i))] = 8'(sl_field(32 + 8 * i, 8));
            end
            last_bits = sl_bits;
            last_dev  = sl_dev;
            last_low  = sl_low;
            miso      = 1'b0;
        end
    end

    // ---------------- one complete transaction ----------------
    task automatic run_txn(input string tag, input bit wr, input logic [24:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, output int lat);
        int nb, nbits, done_cyc, nresp, sel_low, oth_low;
        logic [31:0] got;
        logic sel_n, oth_n;
        nb = size_nb(size);
        nbits = 32 + 8 * nb;
        done_cyc = 2 * nbits + 1;
        lat = 0; nresp = 0; sel_low = 0; oth_low = 0; got = '0;
        @(negedge clk);
        check({tag, " ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata;
        for (int k = 1; k <= done_cyc + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0; req_write = ~wr; req_addr = 25'($urandom);
                req_size = 2'($urandom); req_wdata = $urandom;
                check({tag, " busy/ready c1"}, 32'({busy, req_ready}), 32'b10);
            end
            sel_n = addr[24] ? cs2 : cs1;
            oth_n = addr[24] ? cs1 : cs2;
            if (!sel_n) sel_low++;
            if (!oth_n) oth_low++;
            if (resp_valid) begin
                nresp++;
                if (lat == 0) begin lat = k; got = resp_rdata; end
            end
            if (k == done_cyc) check({tag, " done cs1/cs2/sclk"}, 32'({cs1, cs2, sclk}), 32'b110);
        end
        check({tag, " ready after"}, 32'({req_ready, busy}), 32'b10);
        check({tag, " latency"}, 32'(lat), 32'(done_cyc));
        check({tag, " resp count"}, 32'(nresp), 32'd1);
        check({tag, " rdata"}, got, exp_rd);
        check({tag, " rdata hold"}, resp_rdata, exp_rd);
        check({tag, " cs low cycles"}, 32'(sel_low), 32'(2 * nbits));
        check({tag, " other cs low"}, 32'(oth_low), 32'd0);
        check({tag, " device sel"}, 32'(last_dev), 32'(addr[24]));
        check({tag, " bit count"}, 32'(last_bits.size()), 32'(nbits));
        check({tag, " mosi header"}, last_field(0, 32), {(wr ? 8'h02 : 8'h03), addr[23:0]});
        if (wr) begin
            for (int i = 0; i < nb; i++)
                check($sformatf("%s mosi data%0d", tag, i), last_field(32 + 8 * i, 8),
                      32'(wdata[8*i +: 8]));
        end
    endtask

    typedef struct {
        bit          wr;
        logic [24:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[6];
    int          lat;
    int          nresp, first_ready, r1c, r2c;
    logic [31:0] r1d, r2d, exp2, expd;
    bit          rwr;
    int          rdev, rnb;
    logic [23:0] ra;
    logic [1:0]  rsz;
    logic [31:0] rwd;

    initial begin
        repeat (3) @(negedge clk);
        check("reset cs1/cs2/sclk/mosi", 32'({cs1, cs2, sclk, mosi}), 32'b1100);
        check("reset ready/busy/valid", 32'({req_ready, busy, resp_valid}), 32'b100);
        check("reset rdata", resp_rdata, 32'h0);
        rst = 1'b0;

        preload(0, 24'h000100, 8'h78);
        preload(0, 24'h000101, 8'h56);
        preload(0, 24'h000102, 8'h34);
        preload(0, 24'h000103, 8'h12);
        preload(1, 24'h000200, 8'hCD);
        preload(1, 24'h000201, 8'hAB);

        vecs[0] = '{wr: 1'b0, addr: 25'h0000100, size: 2'd2, wdata: 32'h0,
                    exp_rd: 32'h12345678, exp_lat: 129};
        vecs[1] = '{wr: 1'b1, addr: 25'h1001000, size: 2'd0, wdata: 32'h000000AB,
                    exp_rd: 32'h0, exp_lat: 81};
        vecs[2] = '{wr: 1'b0, addr: 25'h1000200, size: 2'd1, wdata: 32'h0,
                    exp_rd: 32'h0000ABCD, exp_lat: 97};
        vecs[3] = '{wr: 1'b0, addr: 25'h0000100, size: 2'd3, wdata: 32'h0,
                    exp_rd: 32'h12345678, exp_lat: 129};
        vecs[4] = '{wr: 1'b0, addr: 25'h1001000, size: 2'd0, wdata: 32'h0,
                    exp_rd: 32'h000000AB, exp_lat: 81};
        vecs[5] = '{wr: 1'b0, addr: 25'h0000101, size: 2'd1, wdata: 32'h0,
                    exp_rd: 32'h00003456, exp_lat: 97};

        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size,
                    vecs[i].wdata, vecs[i].exp_rd, lat);
            check($sformatf("vec%0d table latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].wr)
                model_write(int'(vecs[i].addr[24]), vecs[i].addr[23:0], size_nb(vecs[i].size),
                            vecs[i].wdata);
        end

        // req_valid held high across two requests.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 25'h0000100; req_size = 2'd2;
        exp2 = model_read(1, 24'h000200, 1);
        nresp = 0; first_ready = 0; r1c = 0; r2c = 0; r1d = '0; r2d = '0;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (k == 2) begin req_addr = 25'h1000200; req_size = 2'd0; end
            if (resp_valid) begin
                nresp++;
                if (nresp == 1) begin r1c = k; r1d = resp_rdata; end
                else if (nresp == 2) begin r2c = k; r2d = resp_rdata; end
            end
            if (req_ready && first_ready == 0) first_ready = k;
            if (first_ready != 0 && k == first_ready + 1) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("b2b second accept cycle", 32'(first_ready), 32'd130);
        check("b2b resp count", 32'(nresp), 32'd2);
        check("b2b resp1 cycle", 32'(r1c), 32'd129);
        check("b2b resp1 data", r1d, 32'h12345678);
        check("b2b resp2 cycle", 32'(r2c), 32'd211);
        check("b2b resp2 data", r2d, exp2);

        // Reset in cycle 40 of a word read.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 25'h0000100; req_size = 2'd2;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
        end
        @(posedge clk);
        #2;
        check("pre-reset cs1 low", 32'(cs1), 32'd0);
        rst = 1'b1;
        #1;
        check("mid reset cs1/cs2/sclk", 32'({cs1, cs2, sclk}), 32'b110);
        check("mid reset ready/busy/valid", 32'({req_ready, busy, resp_valid}), 32'b100);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nresp = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        check("no resp after reset", 32'(nresp), 32'd0);
        run_txn("post-reset", 1'b0, 25'h0000100, 2'd2, 32'h0, 32'h12345678, lat);

        // Randomised traffic against the reference memory.
        for (int t = 0; t < 30; t++) begin
            rwr  = 1'($urandom_range(0, 1));
            rdev = $urandom_range(0, 1);
            ra   = 24'($urandom_range(0, 23));
            if ($urandom_range(0, 4) == 0) ra = 24'hFFFFFC + 24'($urandom_range(0, 3));
            rsz  = 2'($urandom_range(0, 3));
            rwd  = $urandom;
            rnb  = size_nb(rsz);
            expd = rwr ? 32'h0 : model_read(rdev, ra, rnb);
            run_txn($sformatf("rand%0d", t), rwr, {1'(rdev), ra}, rsz, rwd, expd, lat);
            if (rwr) model_write(rdev, ra, rnb, rwd);
        end

        check("both cs never low together", 32'(both_low), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

SPI memory controller that sits directly downstream of the rv32e CPU core inside `tt_um_rv32e_cpu`. It turns single load/store requests into mode-0 SPI transactions on the shared `sclk`/`mosi`/`miso` bus. It drives the two memory chip selects: `cs1` for program flash and `cs2` for data RAM. It returns read data, or a write acknowledge, to the core through a one-request-at-a-time valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, 24: device address bits sent on SPI.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  core request strobe.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  25  [24] device select (0 = `cs1`, 1 = `cs2`); [23:0] device address.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = word (reserved encoding).
- `req_wdata`  in  32  store data, little-endian.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load data, zero-extended; 0 for stores.
- `busy`  out  1  high from acceptance through the DONE cycle.
- `sclk`, `mosi`  out  1  SPI clock and data out.
- `miso`  in  1  SPI data in.
- `cs1`, `cs2`  out  1  active-low chip selects.

## Operation
- Handshake: a request is accepted on a clk edge with `req_valid & req_ready`. Request fields are captured at that edge.
- States: IDLE → CMD (8 bits) → ADDR (24 bits) → DATA (8·N bits) → DONE → IDLE.
  - N = 1, 2 or 4 bytes, from `req_size`.
- Command byte: 0x03 for read, 0x02 for write.
- Address is sent MSB first.
- Data bytes:
  - Byte 0 (lowest address) goes first; each byte is MSB first.
  - Writes shift out `req_wdata[7:0]` first, then higher bytes.
  - Reads place the first received byte in `resp_rdata[7:0]`.
- Only the selected chip select goes low; the other stays high for the whole transaction.
- `miso` is sampled only in DATA of a read.
- Unaligned addresses are passed through unchanged; the device auto-increments.
- Requests presented while busy are ignored; `req_ready` is 0 until the controller returns to IDLE.
- Reset values:
  - `cs1` = `cs2` = 1; `sclk` = 0; `mosi` = 0.
  - `req_ready` = 1; `busy` = 0; `resp_valid` = 0; `resp_rdata` = 0.
- Reset mid-transaction:
  - Chip selects rise immediately (asynchronously).
  - The in-flight request is discarded; no `resp_valid` is issued.

## Timing
- Definitions: handshake edge = cycle 0; B = 32 + 8·N total bits.
- SPI clock is `clk`/2.
- Bit b (0-based) occupies cycles 2b+1 and 2b+2:
  - Cycle 2b+1: `sclk` = 0 and `mosi` holds bit b.
  - Cycle 2b+2: `sclk` = 1.
  - `miso` is sampled on the clk edge that raises `sclk`.
- The selected chip select is low for cycles 1 through 2B.
- DONE is cycle 2B+1:
  - Chip select high, `sclk` = 0.
  - `resp_valid` = 1 and `resp_rdata` is valid in this cycle.
- IDLE is reached at cycle 2B+2, with `req_ready` = 1.
  - Earliest next acceptance is at the end of cycle 2B+2.
- Latency to `resp_valid`: byte 81 cycles, half 97 cycles, word 129 cycles.
- `resp_rdata` holds its value until the next DONE.
- All outputs are registered, except `req_ready` and `busy`, which are decoded from state.

## Structure
- Package `spi_mem_pkg` contains:
  - the state enum;
  - the opcode constants `SPI_OP_READ` = 8'h03 and `SPI_OP_WRITE` = 8'h02;
  - the size encodings;
  - the helper function size → byte count.
- Sub-module `spi_shifter`: the `sclk` phase toggle, bit counter, 32-bit TX shift register and 32-bit RX shift register.
  - `spi_mem_ctrl` keeps the FSM, request capture, chip-select decode and response formatting.

## Test plan
- Word read on `cs1`, address 0x000100, model returns 78 56 34 12:
  - `mosi` = 03 00 01 00.
  - `resp_rdata` = 0x12345678, `resp_valid` in cycle 129.
  - `cs2` stays high throughout.
- Byte write on `cs2`, `req_addr` = 0x1001000, `req_wdata` = 0xAB:
  - `mosi` = 02 00 10 00 AB.
  - `cs2` low for exactly 80 cycles; `resp_valid` in cycle 81 with `resp_rdata` = 0.
- Half read returning CD AB:
  - `resp_rdata` = 0x0000ABCD.
  - `req_size` = 3 behaves identically to a word access (B = 64).
- `req_valid` held high continuously across two requests:
  - Second request is accepted at cycle 130 (end of cycle 2B+2), not earlier.
  - Exactly one `resp_valid` per request.
- Reset asserted at cycle 40 of a read:
  - Chip select high and `sclk` 0 in the same cycle; no `resp_valid`.
  - A subsequent request completes normally.
